// File: rtl/mano_seq_control_pkg.sv
// Shared constants for the Mano control unit: control-word bit map, FSM encoding, opcodes.
// Pure definitions, no logic.
package mano_ctrl_pkg;

  localparam int AR_LD_PC  = 0;
  localparam int AR_LD_IR  = 1;
  localparam int AR_LD_MEM = 2;
  localparam int AR_INC    = 3;
  localparam int IR_LD     = 4;
  localparam int PC_INC    = 5;
  localparam int PC_LD_AR  = 6;
  localparam int MEM_RD    = 7;
  localparam int MEM_WR_AC = 8;
  localparam int MEM_WR_PC = 9;
  localparam int MEM_WR_DR = 10;
  localparam int DR_LD     = 11;
  localparam int DR_INC    = 12;
  localparam int AC_AND    = 13;
  localparam int AC_ADD    = 14;
  localparam int AC_LD_DR  = 15;
  localparam int AC_CLR    = 16;
  localparam int AC_CMP    = 17;
  localparam int AC_SHR    = 18;
  localparam int AC_SHL    = 19;
  localparam int AC_INC    = 20;
  localparam int E_CLR     = 21;
  localparam int E_CMP     = 22;
  localparam int SC_CLR    = 23;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] D_AND = 3'd0;
  localparam logic [2:0] D_ADD = 3'd1;
  localparam logic [2:0] D_LDA = 3'd2;
  localparam logic [2:0] D_STA = 3'd3;
  localparam logic [2:0] D_BUN = 3'd4;
  localparam logic [2:0] D_BSA = 3'd5;
  localparam logic [2:0] D_ISZ = 3'd6;
  localparam logic [2:0] D_REG = 3'd7;

endpackage

// File: rtl/mano_reg_ref_decode.sv
// Register-reference decode: ir[11:0] plus AC/E flags -> control bits and halt request.
// Purely combinational, zero latency; no flow control.
module mano_reg_ref_decode
  import mano_ctrl_pkg::*;
#(
  parameter int CTRL_W = 24
) (
  input  logic [11:0]       ops,
  input  logic              ac_zero,
  input  logic              ac_msb,
  input  logic              e_bit,
  output logic [CTRL_W-1:0] ctrl,
  output logic              halt_req
);

  always_comb begin
    ctrl           = '0;
    ctrl[SC_CLR]   = 1'b1;
    ctrl[AC_CLR]   = ops[11];
    ctrl[E_CLR]    = ops[10];
    ctrl[AC_CMP]   = ops[9];
    ctrl[E_CMP]    = ops[8];
    ctrl[AC_SHR]   = ops[7];
    ctrl[AC_SHL]   = ops[6];
    ctrl[AC_INC]   = ops[5];
    // Any combination of satisfied skip conditions collapses to one PC increment.
    ctrl[PC_INC]   = (ops[4] && !ac_msb) || (ops[3] && ac_msb) ||
                     (ops[2] && ac_zero) || (ops[1] && !e_bit);
    halt_req       = ops[0];
  end

endmodule

// File: rtl/mano_seq_control.sv
// Hardwired Mano control unit: SC-timed control word, IDLE/RUN/HALT FSM, SC overrun trap.
// ctrl is combinational from registered state; instructions take 4..7 clocks, no backpressure.
module mano_seq_control
  import mano_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int SC_W   = 3,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W+3:0] ir,
  input  logic              ac_zero,
  input  logic              ac_msb,
  input  logic              e_bit,
  input  logic              dr_zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic [SC_W-1:0]   t_state,
  output logic              running,
  output logic              halted,
  output logic              sc_err
);

  logic [1:0]        fsm;
  logic [SC_W-1:0]   sc;
  logic [2:0]        d_reg;
  logic              i_reg;
  logic [CTRL_W-1:0] rr_ctrl;
  logic              rr_halt;
  logic [CTRL_W-1:0] raw;
  logic              halt_req;
  logic              overrun;

  mano_reg_ref_decode #(.CTRL_W(CTRL_W)) u_reg_ref (
    .ops      (ir[11:0]),
    .ac_zero  (ac_zero),
    .ac_msb   (ac_msb),
    .e_bit    (e_bit),
    .ctrl     (rr_ctrl),
    .halt_req (rr_halt)
  );

  always_comb begin
    raw      = '0;
    halt_req = 1'b0;
    if (fsm == ST_RUN) begin
      case (int'(sc))
        0: raw[AR_LD_PC] = 1'b1;
        1: begin
          raw[MEM_RD] = 1'b1;
          raw[IR_LD]  = 1'b1;
          raw[PC_INC] = 1'b1;
        end
        2: raw[AR_LD_IR] = 1'b1;
        3: begin
          if (d_reg == D_REG) begin
            if (!i_reg) begin
              raw      = rr_ctrl;
              halt_req = rr_halt;
            end else begin
              raw[SC_CLR] = 1'b1;
            end
          end else if (i_reg) begin
            raw[MEM_RD]    = 1'b1;
            raw[AR_LD_MEM] = 1'b1;
          end
        end
        4: begin
          case (d_reg)
            D_AND, D_ADD, D_LDA, D_ISZ: begin
              raw[MEM_RD] = 1'b1;
              raw[DR_LD]  = 1'b1;
            end
            D_STA: begin
              raw[MEM_WR_AC] = 1'b1;
              raw[SC_CLR]    = 1'b1;
            end
            D_BUN: begin
              raw[PC_LD_AR] = 1'b1;
              raw[SC_CLR]   = 1'b1;
            end
            D_BSA: begin
              raw[MEM_WR_PC] = 1'b1;
              raw[AR_INC]    = 1'b1;
            end
            default: ;
          endcase
        end
        5: begin
          case (d_reg)
            D_AND: begin raw[AC_AND]   = 1'b1; raw[SC_CLR] = 1'b1; end
            D_ADD: begin raw[AC_ADD]   = 1'b1; raw[SC_CLR] = 1'b1; end
            D_LDA: begin raw[AC_LD_DR] = 1'b1; raw[SC_CLR] = 1'b1; end
            D_BSA: begin raw[PC_LD_AR] = 1'b1; raw[SC_CLR] = 1'b1; end
            D_ISZ: raw[DR_INC] = 1'b1;
            default: ;
          endcase
        end
        6: begin
          // dr_zero here already reflects DR after the T5 increment.
          if (d_reg == D_ISZ) begin
            raw[MEM_WR_DR] = 1'b1;
            raw[PC_INC]    = dr_zero;
            raw[SC_CLR]    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign overrun = (fsm == ST_RUN) && (sc == {SC_W{1'b1}}) && !raw[SC_CLR];
  assign ctrl    = overrun ? '0 : raw;
  assign t_state = sc;
  assign running = (fsm == ST_RUN);
  assign halted  = (fsm == ST_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm    <= ST_IDLE;
      sc     <= '0;
      d_reg  <= '0;
      i_reg  <= 1'b0;
      sc_err <= 1'b0;
    end else begin
      case (fsm)
        ST_RUN: begin
          if (overrun) begin
            sc_err <= 1'b1;
            fsm    <= ST_HALT;
            sc     <= '0;
          end else if (halt_req) begin
            fsm <= ST_HALT;
            sc  <= '0;
          end else if (raw[SC_CLR]) begin
            sc <= '0;
          end else begin
            sc <= sc + 1'b1;
          end
          if (int'(sc) == 2) begin
            d_reg <= ir[ADDR_W+2:ADDR_W];
            i_reg <= ir[ADDR_W+3];
          end
        end
        default: begin
          if (start) begin
            fsm <= ST_RUN;
            sc  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mano_seq_control.sv
// Bench for mano_seq_control: directed plan plus random instructions against a table-driven model;
// a second SC_W=2 instance exercises the overrun trap.
module tb_mano_seq_control;

  localparam int C_AR_LD_PC = 0,  C_AR_LD_IR = 1,  C_AR_LD_MEM = 2,  C_AR_INC = 3;
  localparam int C_IR_LD = 4,     C_PC_INC = 5,    C_PC_LD_AR = 6,   C_MEM_RD = 7;
  localparam int C_MEM_WR_AC = 8, C_MEM_WR_PC = 9, C_MEM_WR_DR = 10, C_DR_LD = 11;
  localparam int C_DR_INC = 12,   C_AC_AND = 13,   C_AC_ADD = 14,    C_AC_LD_DR = 15;
  localparam int C_AC_CLR = 16,   C_AC_CMP = 17,   C_AC_SHR = 18,    C_AC_SHL = 19;
  localparam int C_AC_INC = 20,   C_E_CLR = 21,    C_E_CMP = 22,     C_SC_CLR = 23;

  logic        clk = 1'b0;
  logic        reset, reset2, start, start2;
  logic [15:0] ir;
  logic        ac_zero, ac_msb, e_bit, dr_zero;
  logic [23:0] ctrl, ctrl2;
  logic [2:0]  t_state;
  logic [1:0]  t_state2;
  logic        running, halted, sc_err, running2, halted2, sc_err2;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_seq [0:7];
  int          exp_len;
  bit          exp_hlt;

  always #5 clk = ~clk;

  mano_seq_control dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir),
    .ac_zero(ac_zero), .ac_msb(ac_msb), .e_bit(e_bit), .dr_zero(dr_zero),
    .ctrl(ctrl), .t_state(t_state), .running(running), .halted(halted), .sc_err(sc_err)
  );

  mano_seq_control #(.SC_W(2)) u_small (
    .clk(clk), .reset(reset2), .start(start2), .ir(ir),
    .ac_zero(ac_zero), .ac_msb(ac_msb), .e_bit(e_bit), .dr_zero(dr_zero),
    .ctrl(ctrl2), .t_state(t_state2), .running(running2), .halted(halted2), .sc_err(sc_err2)
  );

  function automatic logic [23:0] bm(input int n);
    return 24'd1 << n;
  endfunction

  function automatic int rr_map(input int b);
    case (b)
      11: return C_AC_CLR;
      10: return C_E_CLR;
      9:  return C_AC_CMP;
      8:  return C_E_CMP;
      7:  return C_AC_SHR;
      6:  return C_AC_SHL;
      default: return C_AC_INC;
    endcase
  endfunction

  // Expected per-cycle control words for one instruction, straight from the micro-op table.
  task automatic model(input logic [15:0] w, input bit az, input bit am, input bit eb, input bit dz);
    logic [2:0]  d;
    logic [11:0] op;
    logic [23:0] x;
    bit          ind;
    d   = w[14:12];
    ind = w[15];
    op  = w[11:0];
    for (int k = 0; k < 8; k++) exp_seq[k] = '0;
    exp_hlt    = 1'b0;
    exp_seq[0] = bm(C_AR_LD_PC);
    exp_seq[1] = bm(C_MEM_RD) | bm(C_IR_LD) | bm(C_PC_INC);
    exp_seq[2] = bm(C_AR_LD_IR);
    if (d == 3'd7) begin
      exp_len = 4;
      if (ind) exp_seq[3] = bm(C_SC_CLR);
      else begin
        x = bm(C_SC_CLR);
        for (int b = 5; b <= 11; b++) if (op[b]) x |= bm(rr_map(b));
        if ((op[4] && !am) || (op[3] && am) || (op[2] && az) || (op[1] && !eb)) x |= bm(C_PC_INC);
        exp_hlt    = op[0];
        exp_seq[3] = x;
      end
    end else begin
      exp_seq[3] = ind ? (bm(C_MEM_RD) | bm(C_AR_LD_MEM)) : 24'd0;
      case (d)
        3'd0, 3'd1, 3'd2: begin
          exp_seq[4] = bm(C_MEM_RD) | bm(C_DR_LD);
          exp_seq[5] = bm(C_SC_CLR) | bm(d == 3'd0 ? C_AC_AND : (d == 3'd1 ? C_AC_ADD : C_AC_LD_DR));
          exp_len    = 6;
        end
        3'd3: begin exp_seq[4] = bm(C_MEM_WR_AC) | bm(C_SC_CLR); exp_len = 5; end
        3'd4: begin exp_seq[4] = bm(C_PC_LD_AR) | bm(C_SC_CLR); exp_len = 5; end
        3'd5: begin
          exp_seq[4] = bm(C_MEM_WR_PC) | bm(C_AR_INC);
          exp_seq[5] = bm(C_PC_LD_AR) | bm(C_SC_CLR);
          exp_len    = 6;
        end
        default: begin
          exp_seq[4] = bm(C_MEM_RD) | bm(C_DR_LD);
          exp_seq[5] = bm(C_DR_INC);
          exp_seq[6] = bm(C_MEM_WR_DR) | bm(C_SC_CLR) | (dz ? bm(C_PC_INC) : 24'd0);
          exp_len    = 7;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at a negedge with the DUT showing T0; leaves at the next T0 (or in HALT).
  task automatic run_instr(input logic [15:0] w, input bit az, input bit am, input bit eb,
                           input bit dz, input int stop_at, input bit poke_start);
    ir = w; ac_zero = az; ac_msb = am; e_bit = eb; dr_zero = dz;
    model(w, az, am, eb, dz);
    for (int k = 0; k < exp_len; k++) begin
      chk($sformatf("ctrl ir=%h T%0d", w, k), 32'(ctrl), 32'(exp_seq[k]));
      chk($sformatf("t_state ir=%h", w), 32'(t_state), k);
      chk("running", 32'(running), 1);
      if (k == stop_at) return;
      if (poke_start) start = (k == 1);
      @(negedge clk);
    end
    start = 1'b0;
    if (exp_hlt) begin
      chk("halted after HLT", 32'(halted), 1);
      chk("running after HLT", 32'(running), 0);
      chk("ctrl after HLT", 32'(ctrl), 0);
    end else begin
      chk($sformatf("next t_state ir=%h", w), 32'(t_state), 0);
      chk("still running", 32'(running), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1; start = 1'b0; start2 = 1'b0;
    ir = '0; ac_zero = 0; ac_msb = 0; e_bit = 0; dr_zero = 0;
    repeat (2) @(negedge clk);
    chk("reset ctrl", 32'(ctrl), 0);
    chk("reset t_state", 32'(t_state), 0);
    chk("reset running", 32'(running), 0);
    chk("reset halted", 32'(halted), 0);
    chk("reset sc_err", 32'(sc_err), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle ctrl", 32'(ctrl), 0);
    chk("idle running", 32'(running), 0);
    do_start();

    run_instr(16'h7800, 0, 0, 0, 0, -1, 0);
    run_instr(16'h7001, 0, 0, 0, 0, -1, 0);
    for (int n = 0; n < 10; n++) begin
      chk("halt ctrl", 32'(ctrl), 0);
      chk("halt hold", 32'(halted), 1);
      @(negedge clk);
    end
    do_start();
    chk("restart running", 32'(running), 1);
    chk("restart t_state", 32'(t_state), 0);

    run_instr(16'h7014, 1, 0, 0, 0, -1, 0);
    run_instr(16'h9123, 0, 0, 0, 0, -1, 0);
    run_instr(16'h6050, 0, 0, 0, 1, -1, 0);
    run_instr(16'h6050, 0, 0, 0, 0, -1, 1);

    run_instr(16'h6050, 0, 0, 0, 1, 5, 0);
    reset = 1'b1;
    #1;
    chk("midreset ctrl", 32'(ctrl), 0);
    chk("midreset t_state", 32'(t_state), 0);
    chk("midreset running", 32'(running), 0);
    chk("midreset halted", 32'(halted), 0);
    @(negedge clk);
    reset = 1'b0;
    do_start();

    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[14:12] == 3'd7 && !w[15]) w[0] = ($urandom_range(0, 7) == 0);
      run_instr(w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, 1'($urandom));
      if (exp_hlt) do_start();
    end

    ir = 16'h7800;
    reset2 = 1'b0;
    @(negedge clk);
    chk("small idle sc_err", 32'(sc_err2), 0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    model(16'h7800, ac_zero, ac_msb, e_bit, dr_zero);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("small reg ctrl T%0d", k), 32'(ctrl2), 32'(exp_seq[k]));
      chk("small reg t_state", 32'(t_state2), k);
      @(negedge clk);
    end
    chk("small reg wrap", 32'(t_state2), 0);
    chk("small reg no trap", 32'(sc_err2), 0);
    ir = 16'h6050;
    model(16'h6050, ac_zero, ac_msb, e_bit, dr_zero);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("small isz ctrl T%0d", k), 32'(ctrl2), 32'(exp_seq[k]));
      chk("small isz t_state", 32'(t_state2), k);
      @(negedge clk);
    end
    chk("overrun sc_err", 32'(sc_err2), 1);
    chk("overrun halted", 32'(halted2), 1);
    chk("overrun running", 32'(running2), 0);
    chk("overrun ctrl", 32'(ctrl2), 0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("sticky sc_err", 32'(sc_err2), 1);
    chk("small restart running", 32'(running2), 1);
    chk("small restart t_state", 32'(t_state2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
